// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // One in-flight destination: register index, writes-a-register, is-a-load.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  // EX operand source. FWD_MEM means the producer sits in MEM when the
  // consumer reaches EX; FWD_WB means it has moved on to WB.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Writeback select value that marks a load.
  localparam logic [1:0] WB_SEL_LOAD = 2'b00;

  // Empty slot; only wr matters for matching, the rest is cleared for tidiness.
  localparam sb_entry_t SB_BUBBLE = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};

  // Forwarding priority: the youngest producer (currently in EX) wins.
  function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: ID decode bundle in, pipeline stall/flush/forward controls out.
// Latency: n/a (wires only).
// Backpressure: the stall outputs are the backpressure toward IF/ID.
interface hazard_unit_if #(
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            i_inst_id;
  logic                   i_valid_id;
  logic                   i_rs1_hazard_on_id;
  logic                   i_rs2_hazard_on_id;
  logic                   i_reg_wren_id;
  logic [1:0]             i_wb_sel_id;
  logic                   i_br_taken_ex;
  logic                   o_stall_if;
  logic                   o_stall_id;
  logic                   o_flush_id;
  logic                   o_flush_ex;
  logic [1:0]             o_fwd_a_sel_ex;
  logic [1:0]             o_fwd_b_sel_ex;
  logic [STALL_CNT_W-1:0] o_stall_cycles;

  // Pipeline side: supplies the decode bundle, consumes the controls.
  modport master (
    output i_inst_id, i_valid_id, i_rs1_hazard_on_id, i_rs2_hazard_on_id,
           i_reg_wren_id, i_wb_sel_id, i_br_taken_ex,
    input  o_stall_if, o_stall_id, o_flush_id, o_flush_ex,
           o_fwd_a_sel_ex, o_fwd_b_sel_ex, o_stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  i_inst_id, i_valid_id, i_rs1_hazard_on_id, i_rs2_hazard_on_id,
           i_reg_wren_id, i_wb_sel_id, i_br_taken_ex,
    output o_stall_if, o_stall_id, o_flush_id, o_flush_ex,
           o_fwd_a_sel_ex, o_fwd_b_sel_ex, o_stall_cycles
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: compares one scoreboard slot against the ID source registers.
// Latency: combinational.
// Backpressure: none.
module hazard_match
  import hazard_pkg::*;
(
  input  sb_entry_t  entry,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_on,
  input  logic       rs2_on,
  output logic       rs1_hit,
  output logic       rs2_hit
);

  // Load-ness is judged by the caller; only the EX slot cares about it.
  logic unused_ld;
  assign unused_ld = entry.ld;

  // x0 never matches because wr is already cleared for rd == 0.
  assign rs1_hit = rs1_on & entry.wr & (entry.rd == rs1);
  assign rs2_hit = rs2_on & entry.wr & (entry.rd == rs2);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush control and EX forwarding selects for a 5-stage RV32I pipe.
// Latency: stall/flush combinational from ID; forwarding selects registered, 1 cycle.
// Backpressure: accepts none; o_stall_if/o_stall_id hold the front end while a RAW hazard is open.
// Build option: define HAZARD_FORWARD_EN to include operand forwarding (default: stall-only).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REGFILE_BYPASS = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_unit_if.slave bus
);

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  sb_entry_t  id_entry;
  sb_entry_t  ex_q;
  sb_entry_t  mem_q;
  sb_entry_t  wb_q;

  logic ex_rs1_hit;
  logic ex_rs2_hit;
  logic mem_rs1_hit;
  logic mem_rs2_hit;
  logic wb_rs1_hit;
  logic wb_rs2_hit;

  logic wb_stall;
  logic raw_stall;
  logic stall_gated;
  logic flush_ex;

  logic [STALL_CNT_W-1:0] stall_cnt;

  // Opcode/funct bits are irrelevant to hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{bus.i_inst_id[31:25], bus.i_inst_id[14:12], bus.i_inst_id[6:0]};

  assign rs1 = bus.i_inst_id[19:15];
  assign rs2 = bus.i_inst_id[24:20];
  assign rd  = bus.i_inst_id[11:7];

  // Scoreboard entry the ID instruction would occupy once it reaches EX.
  always_comb begin
    id_entry    = SB_BUBBLE;
    id_entry.rd = rd;
    id_entry.wr = bus.i_reg_wren_id & bus.i_valid_id & (rd != 5'd0);
    id_entry.ld = (bus.i_wb_sel_id == WB_SEL_LOAD);
  end

  hazard_match u_match_ex (
    .entry   (ex_q),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_on  (bus.i_rs1_hazard_on_id),
    .rs2_on  (bus.i_rs2_hazard_on_id),
    .rs1_hit (ex_rs1_hit),
    .rs2_hit (ex_rs2_hit)
  );

  hazard_match u_match_mem (
    .entry   (mem_q),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_on  (bus.i_rs1_hazard_on_id),
    .rs2_on  (bus.i_rs2_hazard_on_id),
    .rs1_hit (mem_rs1_hit),
    .rs2_hit (mem_rs2_hit)
  );

  hazard_match u_match_wb (
    .entry   (wb_q),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_on  (bus.i_rs1_hazard_on_id),
    .rs2_on  (bus.i_rs2_hazard_on_id),
    .rs1_hit (wb_rs1_hit),
    .rs2_hit (wb_rs2_hit)
  );

  // Without write-before-read in the register file, a value still in WB
  // is not yet visible to the ID read, so that case must wait too.
  assign wb_stall = (REGFILE_BYPASS == 0) & (wb_rs1_hit | wb_rs2_hit);

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign raw_stall = (ex_q.ld & (ex_rs1_hit | ex_rs2_hit)) | wb_stall;
`else
  // No bypass network: wait until the producer has left every checked slot.
  assign raw_stall = ex_rs1_hit | ex_rs2_hit | mem_rs1_hit | mem_rs2_hit | wb_stall;
`endif

  // A taken branch discards the ID instruction, so its hazard no longer matters.
  assign stall_gated    = raw_stall & ~bus.i_br_taken_ex;
  assign flush_ex       = raw_stall | bus.i_br_taken_ex;

  assign bus.o_stall_if = stall_gated;
  assign bus.o_stall_id = stall_gated;
  assign bus.o_flush_id = bus.i_br_taken_ex;
  assign bus.o_flush_ex = flush_ex;

  // Advance the in-flight destination window; a flushed or empty ID slot enters as a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (flush_ex | ~bus.i_valid_id) ? SB_BUBBLE : id_entry;
    end
  end

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e fwd_a_d;
  fwd_sel_e fwd_b_d;
  fwd_sel_e fwd_a_q;
  fwd_sel_e fwd_b_q;

  // Selects are decided from the pre-shift slots, i.e. where the producers
  // will be one stage further on when this instruction executes.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!flush_ex) begin
      fwd_a_d = fwd_pick(ex_rs1_hit, mem_rs1_hit);
      fwd_b_d = fwd_pick(ex_rs2_hit, mem_rs2_hit);
    end
  end

  // Forwarding selects travel with the instruction into EX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.o_fwd_a_sel_ex = fwd_a_q;
  assign bus.o_fwd_b_sel_ex = fwd_b_q;
`else
  assign bus.o_fwd_a_sel_ex = FWD_RF;
  assign bus.o_fwd_b_sel_ex = FWD_RF;
`endif

  // Stalled-cycle statistics; holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (stall_gated && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_stall_cycles = stall_cnt;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer side of the ID-stage decode control bundle: rs1/rs2 hazard-enable flags, reg write-enable, writeback select and instruction fields.
- Keeps its own 3-entry scoreboard of in-flight destinations (EX, MEM, WB slots).
- From that scoreboard it produces pipeline stall/flush controls and registered EX-stage operand forwarding selects for the 5-stage RV32I pipeline.
- Sits beside the ID/EX pipeline register.

Parameters:
- REGFILE_BYPASS, 1, 1 = register file is write-before-read, so the WB slot never causes a hazard; 0 = a WB-slot match is a hazard.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_inst_id  input  32  ID instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- i_valid_id  input  1  ID holds a real instruction
- i_rs1_hazard_on_id  input  1  instruction reads rs1
- i_rs2_hazard_on_id  input  1  instruction reads rs2
- i_reg_wren_id  input  1  instruction writes rd
- i_wb_sel_id  input  2  00 = load, 01 = ALU, 10 = PC+4
- i_br_taken_ex  input  1  branch/jump resolved taken in EX
- o_stall_if  output  1  hold PC
- o_stall_id  output  1  hold IF/ID register
- o_flush_id  output  1  clear IF/ID register
- o_flush_ex  output  1  load bubble into ID/EX register
- o_fwd_a_sel_ex  output  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB data
- o_fwd_b_sel_ex  output  2  EX operand B source, same encoding as A
- o_stall_cycles  output  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Slot contents: {rd[4:0], wr, ld}.
- wr = i_reg_wren_id & i_valid_id & (rd != 0); ld = (i_wb_sel_id == 00).
- Match on rs1 for slot S: i_rs1_hazard_on_id & S.wr & (S.rd == rs1). Same rule for rs2.
- Stall, forwarding compiled in:
  - stall = EX.ld & EX-match.
  - When REGFILE_BYPASS=0, WB-match also stalls.
- Stall, forwarding compiled out:
  - stall = any match in EX or MEM.
  - When REGFILE_BYPASS=0, WB also counts.
- Combinational control outputs:
  - o_stall_if = o_stall_id = stall & ~i_br_taken_ex.
  - o_flush_ex = stall | i_br_taken_ex.
  - o_flush_id = i_br_taken_ex.
  - A taken branch overrides the stall: the ID instruction is discarded, so its hazard is moot.
- Scoreboard update every cycle, no enable:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (wr=0) if o_flush_ex or ~i_valid_id; otherwise the ID entry.
- Forwarding selects:
  - Registered; computed in ID from pre-shift slots; loaded into o_fwd_*_ex on the same edge that moves ID into EX.
  - Priority for each operand: EX-match -> 01; else MEM-match -> 10; else 00.
  - 00 is forced when the corresponding hazard_on flag is 0, rd = 0, or o_flush_ex = 1.
- o_stall_cycles:
  - Increments when o_stall_id = 1.
  - Saturates at all-ones, never wraps.
- Reset (synchronous, i_rst=1 at an edge):
  - All slots become bubbles.
  - o_fwd_*_ex = 00; o_stall_cycles = 0.
  - Combinational outputs are therefore 0 on the next cycle unless i_br_taken_ex is set.
  - Reset mid-stall abandons the stall immediately.
- Simultaneous stall and taken branch: flush wins; stall outputs 0; the counter does not increment.
- Load-use stall resolves in exactly 1 cycle, because the load moves to MEM and forwarding takes over.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined:
  - Forwarding logic is present.
  - Only the load-use case stalls (plus the WB case when REGFILE_BYPASS=0).
- Undefined:
  - o_fwd_a_sel_ex and o_fwd_b_sel_ex are tied to 00.
  - Every RAW dependency on EX/MEM (and WB when REGFILE_BYPASS=0) stalls until the producer leaves the checked slots: up to 2 cycles with bypass, 3 without.

Decomposition:
- Shared package hazard_pkg:
  - typedef sb_entry_t {rd, wr, ld}.
  - typedef fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - constant WB_SEL_LOAD = 2'b00.
- One natural sub-module: hazard_match. It is combinational and takes one sb_entry_t plus rs1/rs2 and the hazard_on flags. It returns rs1_hit/rs2_hit and is instantiated three times.

Test Plan:
- lw x5 followed by add x6,x5,x1 (forwarding on) -> exactly 1 cycle of o_stall_id=1 and o_flush_ex=1; next edge o_fwd_a_sel_ex=10; o_stall_cycles=1.
- add x5 followed by sub x7,x1,x5 -> no stall; o_fwd_b_sel_ex=01 one cycle later. Inserting a nop between them -> 10.
- addi x0,x0,1 followed by add x2,x0,x0 -> no stall; both fwd selects 00 (rd=0 exclusion).
- Load-use stall with i_br_taken_ex=1 in the same cycle -> o_stall_id=0, o_flush_id=1, o_flush_ex=1; counter unchanged.
- Forwarding compiled out: add x5 followed by add x6,x5,x5 -> 2 stall cycles (REGFILE_BYPASS=1), 3 cycles with REGFILE_BYPASS=0.
- Assert i_rst during a stall -> next cycle all outputs 0 and slots empty. Then drive 2^STALL_CNT_W+3 stalled cycles -> o_stall_cycles saturates at all-ones.
